// File: rtl/burst_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// burst_deserializer_pkg
// Shared definitions for the burst deserializer slice.
//   DESER_WIDTH : default burst / word width, shared with the iterator that
//                 generates the 16-cycle sampling window.
//   state_t     : collection FSM states.
// ---------------------------------------------------------------------------
package burst_deserializer_pkg;

  localparam int DESER_WIDTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage : burst_deserializer_pkg

// File: rtl/burst_deserializer_if.sv
// ---------------------------------------------------------------------------
// burst_deserializer_if
// Valid/ready read port of the deserializer's one-entry holding register.
//   word       : holding-register contents (producer -> consumer)
//   word_valid : holding register holds an unconsumed word
//   rd_ready   : consumer accepts the word on this edge (consumer -> producer)
// Modports: master = deserializer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface burst_deserializer_if
  import burst_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
);

  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             rd_ready;

  modport master (
    output word,
    output word_valid,
    input  rd_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    output rd_ready
  );

endinterface : burst_deserializer_if

// File: rtl/burst_deserializer_output_holding_reg.sv
// ---------------------------------------------------------------------------
// output_holding_reg
// One-entry valid/ready holding register with commit, pop and sticky overrun.
//   clk, rst_n   : clock, asynchronous active-low reset
//   commit       : a new word is offered this edge (commit_data)
//   commit_data  : word to store on commit
//   rd_ready     : consumer ready; with word_valid forms a transfer
//   clr_status   : synchronous clear of overrun (a simultaneous set wins)
//   word         : stored word, stable while valid and not transferred
//   word_valid   : register holds an unconsumed word
//   overrun      : sticky, a committed word was dropped because it was full
// A commit is accepted when the register is empty or is being popped on the
// same edge; otherwise the new word is dropped and the old one is kept.
// ---------------------------------------------------------------------------
module output_holding_reg
  import burst_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_data,
  input  logic             rd_ready,
  input  logic             clr_status,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             overrun
);

  logic pop;
  logic accept;

  assign pop    = word_valid && rd_ready;
  assign accept = commit && (!word_valid || rd_ready);

  // NOTE: the data register is reset along with its valid bit because the
  // word output is architecturally visible as zero after reset; a pure
  // datapath register that nobody reads before valid could skip the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        word       <= commit_data;
        word_valid <= 1'b1;
      end else if (pop) begin
        word_valid <= 1'b0;
      end

      // Set has priority over clear so a drop is never lost.
      if (commit && !accept) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule : output_holding_reg

// File: rtl/burst_deserializer.sv
// ---------------------------------------------------------------------------
// burst_deserializer
// Samples one serial bit per cycle while the iterator window (en) is high and
// assembles a WIDTH-bit word. When the window closes the bit count is checked;
// a correct-length word is committed to a one-entry holding register drained
// over a valid/ready port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : burst window, high for WIDTH consecutive cycles per burst
//   sdata       : serial data, sampled on every edge with en=1
//   clr_status  : synchronous clear of the sticky overrun flag
//   rd          : valid/ready read port (word, word_valid, rd_ready)
//   len_err     : one-cycle pulse, burst closed with bit count != WIDTH
//   overrun     : sticky, a good word was dropped because the register was full
//   busy        : registered, high while in COLLECT
// ---------------------------------------------------------------------------
module burst_deserializer
  import burst_deserializer_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sdata,
  input  logic                 clr_status,
  burst_deserializer_if.master rd,
  output logic                 len_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  // Shift direction decides where the first sampled bit ends up after
  // exactly WIDTH shifts: word[WIDTH-1] when MSB-first, word[0] otherwise.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr[WIDTH-2:0], sdata};
    end else begin : g_lsb_first
      assign sr_shifted = {sdata, sr[WIDTH-1:1]};
    end
  endgenerate

  // Commit is evaluated on the closing edge itself so word_valid rises on
  // the first edge that samples en=0.
  assign commit = (state == COLLECT) && !en && (cnt == CNT_FULL);

  // NOTE: all state in this block uses non-blocking assignments so every
  // register sees the pre-edge value of the others (cnt compare vs update).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            sr    <= sr_shifted;
            cnt   <= CNT_W'(1);
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (en) begin
            // Long bursts keep shifting; the count saturates one past full
            // so it can never wrap back to a "correct" length.
            sr <= sr_shifted;
            if (cnt != CNT_SAT) begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            len_err <= (cnt != CNT_FULL);
            cnt     <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  output_holding_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .commit      (commit),
    .commit_data (sr),
    .rd_ready    (rd.rd_ready),
    .clr_status  (clr_status),
    .word        (rd.word),
    .word_valid  (rd.word_valid),
    .overrun     (overrun)
  );

endmodule : burst_deserializer

// File: tb/tb_burst_deserializer.sv
// ---------------------------------------------------------------------------
// tb_burst_deserializer
// Drives bursts into an MSB-first and an LSB-first deserializer sharing the
// same window and serial line. Good MSB-first words are queued as expected
// results and compared when the read port transfers them.
// ---------------------------------------------------------------------------
module tb_burst_deserializer;
  import burst_deserializer_pkg::*;

  localparam int WIDTH = DESER_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  logic en = 1'b0;
  logic sdata = 1'b0;
  logic clr_status = 1'b0;
  logic len_err, overrun, busy;
  logic lsb_len_err, lsb_overrun, lsb_busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mon_exp;

  burst_deserializer_if #(.WIDTH(WIDTH)) rd_if ();
  burst_deserializer_if #(.WIDTH(WIDTH)) lsb_if ();

  always #5 clk = ~clk;

  burst_deserializer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sdata      (sdata),
    .clr_status (clr_status),
    .rd         (rd_if.master),
    .len_err    (len_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  burst_deserializer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sdata      (sdata),
    .clr_status (clr_status),
    .rd         (lsb_if.master),
    .len_err    (lsb_len_err),
    .overrun    (lsb_overrun),
    .busy       (lsb_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Sends len bits of data MSB-first (wrapping for long bursts), then the
  // closing en=0 edge. Outputs reflect the closing edge on return.
  task automatic send_burst(input logic [WIDTH-1:0] data, input int len,
                            input bit ready_at_close);
    for (int i = 0; i < len; i++) begin
      en    = 1'b1;
      sdata = data[WIDTH-1-(i % WIDTH)];
      tick();
      if (i == 0) check("busy_in_burst", 32'(busy), 32'd1);
    end
    en             = 1'b0;
    sdata          = 1'b0;
    rd_if.rd_ready = ready_at_close;
    tick();
    rd_if.rd_ready = 1'b0;
    check("busy_after_close", 32'(busy), 32'd0);
  endtask

  task automatic pop_word();
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    check("valid_after_pop", 32'(rd_if.word_valid), 32'd0);
  endtask

  // Scoreboard: a transfer happens on the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && rd_if.word_valid && rd_if.rd_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'(rd_if.word), 32'hDEAD_BEEF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_word", 32'(rd_if.word), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_if.rd_ready  = 1'b0;
    lsb_if.rd_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_word",    32'(rd_if.word),       32'd0);
    check("rst_valid",   32'(rd_if.word_valid), 32'd0);
    check("rst_len_err", 32'(len_err),          32'd0);
    check("rst_overrun", 32'(overrun),          32'd0);
    check("rst_busy",    32'(busy),             32'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();

    // Normal burst, then pop.
    exp_q.push_back(16'hA5C3);
    send_burst(16'hA5C3, WIDTH, 1'b0);
    check("normal_word",    32'(rd_if.word),       32'hA5C3);
    check("normal_valid",   32'(rd_if.word_valid), 32'd1);
    check("normal_len_err", 32'(len_err),          32'd0);
    check("normal_lsb",     32'(lsb_if.word),      32'(reverse(16'hA5C3)));
    pop_word();

    // rd_ready with nothing held has no effect.
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    check("idle_ready_valid", 32'(rd_if.word_valid), 32'd0);
    check("idle_ready_word",  32'(rd_if.word),       32'hA5C3);

    // Short and long bursts.
    send_burst(16'h0F0F, WIDTH - 1, 1'b0);
    check("short_len_err", 32'(len_err),          32'd1);
    check("short_valid",   32'(rd_if.word_valid), 32'd0);
    tick();
    check("short_len_err_pulse", 32'(len_err), 32'd0);
    send_burst(16'h0F0F, WIDTH + 1, 1'b0);
    check("long_len_err",  32'(len_err),          32'd1);
    check("long_valid",    32'(rd_if.word_valid), 32'd0);
    check("long_word",     32'(rd_if.word),       32'hA5C3);
    tick();
    check("long_len_err_pulse", 32'(len_err), 32'd0);

    // Overrun: second good word dropped while the first is held.
    exp_q.push_back(16'h1234);
    send_burst(16'h1234, WIDTH, 1'b0);
    send_burst(16'hBEEF, WIDTH, 1'b0);
    check("ovr_word",    32'(rd_if.word),       32'h1234);
    check("ovr_valid",   32'(rd_if.word_valid), 32'd1);
    check("ovr_flag",    32'(overrun),          32'd1);
    check("ovr_len_err", 32'(len_err),          32'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_overrun", 32'(overrun),    32'd0);
    check("clr_word",    32'(rd_if.word), 32'h1234);
    pop_word();

    // Commit and pop on the same edge.
    exp_q.push_back(16'h1111);
    send_burst(16'h1111, WIDTH, 1'b0);
    exp_q.push_back(16'h2222);
    send_burst(16'h2222, WIDTH, 1'b1);
    check("swap_word",    32'(rd_if.word),       32'h2222);
    check("swap_valid",   32'(rd_if.word_valid), 32'd1);
    check("swap_overrun", 32'(overrun),          32'd0);
    pop_word();

    // Reset in the middle of a burst.
    for (int i = 0; i < 8; i++) begin
      en    = 1'b1;
      sdata = i[0];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),             32'd0);
    check("mid_rst_word",  32'(rd_if.word),       32'd0);
    check("mid_rst_valid", 32'(rd_if.word_valid), 32'd0);
    en = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    exp_q.push_back(16'hFFFF);
    send_burst(16'hFFFF, WIDTH, 1'b0);
    check("post_rst_word",    32'(rd_if.word), 32'hFFFF);
    check("post_rst_len_err", 32'(len_err),    32'd0);
    pop_word();

    // First bit 1, rest 0: MSB-first gives 0x8000, LSB-first gives 0x0001.
    exp_q.push_back(16'h8000);
    send_burst(16'h8000, WIDTH, 1'b0);
    check("msb_first_word", 32'(rd_if.word),  32'h8000);
    check("lsb_first_word", 32'(lsb_if.word), 32'h0001);
    pop_word();

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_burst_deserializer
